// File: rtl/key_action_decoder.sv
// Turns one sampled USB HID keycode per frame into piece-move requests:
// left/right shift with delayed auto-shift and auto-repeat, rotate, soft drop.
module key_action_decoder #(
   parameter int unsigned DAS_FRAMES = 10,
   parameter int unsigned ARR_FRAMES = 3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       left_pulse,
   output logic       right_pulse,
   output logic       rotate_pulse,
   output logic       drop_hold,
   output logic       started,
   output logic [1:0] rep_state
);

   localparam int unsigned KEY_W = 8;
   localparam int unsigned CNT_W = 6;

   localparam logic [KEY_W-1:0] KEY_LEFT   = 8'h50;
   localparam logic [KEY_W-1:0] KEY_RIGHT  = 8'h4F;
   localparam logic [KEY_W-1:0] KEY_ROTATE = 8'h52;
   localparam logic [KEY_W-1:0] KEY_DROP   = 8'h51;

   localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_FRAMES - 1);
   localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DAS    = 2'd1,
      ST_REPEAT = 2'd2
   } rep_state_e;

   logic [KEY_W-1:0] key_q, key_d;
   logic [KEY_W-1:0] prev_q, prev_d;
   rep_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             left_q, left_d;
   logic             right_q, right_d;
   logic             rotate_q, rotate_d;
   logic             drop_q, drop_d;
   logic             started_q, started_d;

   logic             key_is_left;
   logic             key_is_right;
   logic             key_horiz;
   logic             key_known;
   logic             new_press;
   logic [KEY_W-1:0] held_key;
   logic [CNT_W-1:0] cnt_last;

   always_comb begin
      key_is_left  = (key_q == KEY_LEFT);
      key_is_right = (key_q == KEY_RIGHT);
      key_horiz    = key_is_left | key_is_right;
      key_known    = key_horiz | (key_q == KEY_ROTATE) | (key_q == KEY_DROP);
      new_press    = (key_q != prev_q) & key_known;
      held_key     = dir_q ? KEY_RIGHT : KEY_LEFT;
      cnt_last     = (state_q == ST_DAS) ? DAS_LAST : ARR_LAST;
   end

   // Next-state and registered-output logic; terminal compare precedes increment so cnt never wraps.
   always_comb begin
      key_d     = keycode;
      prev_d    = key_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      left_d    = 1'b0;
      right_d   = 1'b0;
      rotate_d  = new_press & (key_q == KEY_ROTATE);
      drop_d    = (key_q == KEY_DROP);
      started_d = started_q | key_known;

      case (state_q)
         ST_IDLE: begin
            if (new_press && key_horiz) begin
               left_d  = key_is_left;
               right_d = key_is_right;
               dir_d   = key_is_right;
               cnt_d   = CNT_W'(1);
               state_d = ST_DAS;
            end
         end
         ST_DAS, ST_REPEAT: begin
            if (key_q == held_key) begin
               if (cnt_q == cnt_last) begin
                  left_d  = ~dir_q;
                  right_d = dir_q;
                  cnt_d   = '0;
                  state_d = ST_REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (key_horiz) begin
               // Direct switch to the opposite direction restarts the DAS delay.
               left_d  = key_is_left;
               right_d = key_is_right;
               dir_d   = key_is_right;
               cnt_d   = CNT_W'(1);
               state_d = ST_DAS;
            end else begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         key_q     <= '0;
         prev_q    <= '0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         left_q    <= 1'b0;
         right_q   <= 1'b0;
         rotate_q  <= 1'b0;
         drop_q    <= 1'b0;
         started_q <= 1'b0;
      end else begin
         key_q     <= key_d;
         prev_q    <= prev_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         left_q    <= left_d;
         right_q   <= right_d;
         rotate_q  <= rotate_d;
         drop_q    <= drop_d;
         started_q <= started_d;
      end
   end

   assign left_pulse   = left_q;
   assign right_pulse  = right_q;
   assign rotate_pulse = rotate_q;
   assign drop_hold    = drop_q;
   assign started      = started_q;
   assign rep_state    = state_q;

endmodule

// File: tb/tb_key_action_decoder.sv
// Bench for key_action_decoder: directed scenarios plus random key streams
// against a run-length model of the key history.
module tb_key_action_decoder;

   localparam int DAS = 10;
   localparam int ARR = 3;

   localparam logic [7:0] K_L    = 8'h50;
   localparam logic [7:0] K_R    = 8'h4F;
   localparam logic [7:0] K_ROT  = 8'h52;
   localparam logic [7:0] K_DROP = 8'h51;
   localparam logic [7:0] K_NONE = 8'h00;

   logic       frame_clk = 1'b0;
   logic       Reset     = 1'b1;
   logic [7:0] keycode   = 8'h00;
   logic       left_pulse, right_pulse, rotate_pulse, drop_hold, started;
   logic [1:0] rep_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: key_q / prev_q samples and length of the current run of identical samples.
   logic [6:0] exp_v;
   logic [7:0] m_cur  = 8'h00;
   logic [7:0] m_prev = 8'h00;
   int         m_run  = 1;
   logic       m_started = 1'b0;

   key_action_decoder #(.DAS_FRAMES(DAS), .ARR_FRAMES(ARR)) dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .left_pulse  (left_pulse),
      .right_pulse (right_pulse),
      .rotate_pulse(rotate_pulse),
      .drop_hold   (drop_hold),
      .started     (started),
      .rep_state   (rep_state)
   );

   always #5 frame_clk = ~frame_clk;

   function automatic logic known(input logic [7:0] k);
      return (k == K_L) || (k == K_R) || (k == K_ROT) || (k == K_DROP);
   endfunction

   function automatic logic [6:0] obs();
      return {left_pulse, right_pulse, rotate_pulse, drop_hold, started, rep_state};
   endfunction

   // Drive one frame, advance the model across the edge, then settle past the edge.
   task automatic step(input logic [7:0] k, input logic r);
      logic       hp;
      logic [1:0] rs;
      keycode = k;
      Reset   = r;
      @(posedge frame_clk);
      if (r) begin
         exp_v     = '0;
         m_cur     = 8'h00;
         m_prev    = 8'h00;
         m_run     = 1;
         m_started = 1'b0;
      end else begin
         hp = 1'b0;
         rs = 2'd0;
         if (m_cur == K_L || m_cur == K_R) begin
            hp = (m_run == 1) || (m_run == DAS) || (m_run > DAS && ((m_run - DAS) % ARR) == 0);
            rs = (m_run < DAS) ? 2'd1 : 2'd2;
         end
         m_started = m_started | known(m_cur);
         exp_v = {hp && (m_cur == K_L), hp && (m_cur == K_R),
                  (m_cur == K_ROT) && (m_prev != K_ROT), m_cur == K_DROP, m_started, rs};
         m_run  = (k == m_cur) ? m_run + 1 : 1;
         m_prev = m_cur;
         m_cur  = k;
      end
      #1;
   endtask

   task automatic test_reset();
      step(K_L, 1'b1);
      n_checks++;
      if (obs() !== 7'b0) $display("FAIL reset_priority: got %b want %b", obs(), 7'b0);
      else n_pass++;
      step(K_ROT, 1'b1);
      n_checks++;
      if (obs() !== 7'b0) $display("FAIL reset_hold: got %b want %b", obs(), 7'b0);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         step(K_NONE, 1'b0);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL reset_idle step %0d: got %b want %b", i, obs(), exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_tap_left();
      int n_left = 0;
      step(K_L, 1'b0);
      n_left += int'(left_pulse);
      for (int i = 0; i < 5; i++) begin
         step(K_NONE, 1'b0);
         n_left += int'(left_pulse);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL tap step %0d: got %b want %b", i, obs(), exp_v);
         else n_pass++;
      end
      n_checks++;
      if (n_left != 1 || rep_state !== 2'd0 || started !== 1'b1)
         $display("FAIL tap_summary: got lefts=%0d rep=%0d started=%b want 1/0/1", n_left, rep_state, started);
      else n_pass++;
   endtask

   task automatic test_hold_right();
      logic [31:0] mask = '0;
      logic [31:0] want = (32'd1 << 1) | (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19);
      for (int s = 0; s < 23; s++) begin
         step((s < 20) ? K_R : K_NONE, 1'b0);
         if (right_pulse === 1'b1) mask[s] = 1'b1;
         n_checks++;
         if (obs() !== exp_v) $display("FAIL hold_right step %0d: got %b want %b", s, obs(), exp_v);
         else n_pass++;
      end
      n_checks++;
      if (mask !== want) $display("FAIL hold_right_cycles: got %h want %h", mask, want);
      else n_pass++;
   endtask

   task automatic test_switch();
      int late_left = 0;
      step(K_NONE, 1'b0);
      step(K_NONE, 1'b0);
      for (int s = 0; s < 19; s++) begin
         step((s < 5) ? K_L : ((s < 17) ? K_R : K_NONE), 1'b0);
         if (s >= 6) late_left += int'(left_pulse);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL switch step %0d: got %b want %b", s, obs(), exp_v);
         else n_pass++;
         if (s == 6) begin
            n_checks++;
            if (right_pulse !== 1'b1 || rep_state !== 2'd1)
               $display("FAIL switch_immediate: got right=%b rep=%0d want 1/1", right_pulse, rep_state);
            else n_pass++;
         end
         if (s == 15) begin
            n_checks++;
            if (right_pulse !== 1'b1 || rep_state !== 2'd2)
               $display("FAIL switch_das_restart: got right=%b rep=%0d want 1/2", right_pulse, rep_state);
            else n_pass++;
         end
      end
      n_checks++;
      if (late_left != 0) $display("FAIL switch_no_left: got %0d want 0", late_left);
      else n_pass++;
   endtask

   task automatic test_rotate_hold();
      int n_rot = 0;
      int n_busy = 0;
      for (int s = 0; s < 32; s++) begin
         step((s < 30) ? K_ROT : K_NONE, 1'b0);
         n_rot += int'(rotate_pulse);
         if (rep_state !== 2'd0) n_busy++;
         n_checks++;
         if (obs() !== exp_v) $display("FAIL rotate step %0d: got %b want %b", s, obs(), exp_v);
         else n_pass++;
      end
      n_checks++;
      if (n_rot != 1 || n_busy != 0)
         $display("FAIL rotate_once: got pulses=%0d non_idle=%0d want 1/0", n_rot, n_busy);
      else n_pass++;
   endtask

   task automatic test_drop();
      logic [9:0] mask = '0;
      int n_pulse = 0;
      for (int s = 0; s < 10; s++) begin
         step((s < 6) ? K_DROP : K_NONE, 1'b0);
         mask[s] = drop_hold;
         n_pulse += int'(left_pulse) + int'(right_pulse) + int'(rotate_pulse);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL drop step %0d: got %b want %b", s, obs(), exp_v);
         else n_pass++;
      end
      n_checks++;
      if (mask !== 10'b00_0111_1110 || n_pulse != 0)
         $display("FAIL drop_window: got mask=%b pulses=%0d want 0001111110/0", mask, n_pulse);
      else n_pass++;
   endtask

   task automatic test_reset_mid_hold();
      step(K_NONE, 1'b0);
      step(K_NONE, 1'b0);
      for (int s = 0; s < 11; s++) begin
         step(K_L, 1'b0);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL midrst_pre step %0d: got %b want %b", s, obs(), exp_v);
         else n_pass++;
      end
      for (int s = 0; s < 2; s++) begin
         step(K_L, 1'b1);
         n_checks++;
         if (obs() !== 7'b0) $display("FAIL midrst_in_reset %0d: got %b want %b", s, obs(), 7'b0);
         else n_pass++;
      end
      for (int p = 0; p < 14; p++) begin
         step((p < 12) ? K_L : K_NONE, 1'b0);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL midrst_post step %0d: got %b want %b", p, obs(), exp_v);
         else n_pass++;
         if (p == 0) begin
            n_checks++;
            if (obs() !== 7'b0) $display("FAIL midrst_first: got %b want %b", obs(), 7'b0);
            else n_pass++;
         end
         if (p == 1) begin
            n_checks++;
            if (obs() !== 7'b1000101) $display("FAIL midrst_fresh_press: got %b want %b", obs(), 7'b1000101);
            else n_pass++;
         end
         if (p == 10) begin
            n_checks++;
            if (left_pulse !== 1'b1) $display("FAIL midrst_das_restart: got %b want 1", left_pulse);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] k = K_NONE;
      logic [7:0] pool [5] = '{K_NONE, K_L, K_R, K_ROT, K_DROP};
      logic       r;
      for (int s = 0; s < 600; s++) begin
         if ($urandom_range(0, 99) >= 80) begin
            if ($urandom_range(0, 9) == 0) k = 8'($urandom);
            else k = pool[$urandom_range(0, 4)];
         end
         r = ($urandom_range(0, 99) < 2);
         step(k, r);
         n_checks++;
         if (obs() !== exp_v) $display("FAIL random step %0d key %h: got %b want %b", s, k, obs(), exp_v);
         else n_pass++;
         n_checks++;
         if ($countones({left_pulse, right_pulse, rotate_pulse, drop_hold}) > 1)
            $display("FAIL random_onehot step %0d: got %b want at most one", s,
                     {left_pulse, right_pulse, rotate_pulse, drop_hold});
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_tap_left();
      test_hold_right();
      test_switch();
      test_rotate_hold();
      test_drop();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/key_action_decoder.md
KEY_ACTION_DECODER -- requirements
Module: key_action_decoder

Interface
REQ-001 Parameter DAS_FRAMES, default 10, frames a left/right key is held before auto-repeat begins; legal range 2..63.
REQ-002 Parameter ARR_FRAMES, default 3, frames between auto-repeat pulses; legal range 1..63.
REQ-003 frame_clk  input  1  frame-rate clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 keycode  input  8  current USB HID keycode; 0x00 = no key; 0x50 left, 0x4F right, 0x52 rotate, 0x51 soft drop.
REQ-006 left_pulse  output  1  one-cycle request to shift the active piece one column left.
REQ-007 right_pulse  output  1  one-cycle request to shift the active piece one column right.
REQ-008 rotate_pulse  output  1  one-cycle request to rotate the active piece.
REQ-009 drop_hold  output  1  level; soft drop requested this frame.
REQ-010 started  output  1  sticky; high once any recognized key has been pressed.
REQ-011 rep_state  output  2  horizontal FSM state: 0 IDLE, 1 DAS, 2 REPEAT.

Function
REQ-012 All outputs SHALL be registered; keycode is sampled once per rising edge into key_q, with prev_q holding the previous sample.
REQ-013 A new press SHALL be key_q != prev_q with key_q recognized; any key_q not in {0x50,0x4F,0x52,0x51} counts as a release.
REQ-014 Response latency SHALL be one cycle: a keycode first present before edge k yields its pulse in the cycle after edge k+1.
REQ-015 The horizontal FSM SHALL keep a 6-bit frame counter cnt and a direction bit dir (0 left, 1 right).
REQ-016 IDLE: on a new press of 0x50 or 0x4F, fire the matching pulse, set dir, set cnt=1, go to DAS.
REQ-017 DAS: while key_q still equals the dir key, increment cnt; when cnt reaches DAS_FRAMES-1, fire a pulse, clear cnt, go to REPEAT.
REQ-018 REPEAT: while held, increment cnt; when cnt reaches ARR_FRAMES-1, fire a pulse and clear cnt; with ARR_FRAMES=1 the pulse fires every cycle.
REQ-019 In DAS or REPEAT, a new press of the opposite direction SHALL fire the opposite pulse immediately, flip dir, set cnt=1, and go to DAS.
REQ-020 In DAS or REPEAT, key_q becoming any non-horizontal value SHALL return the FSM to IDLE with cnt=0 and no pulse.
REQ-021 left_pulse and right_pulse SHALL never be high in the same cycle.
REQ-022 rotate_pulse SHALL fire exactly once per new press of 0x52, with no auto-repeat while held.
REQ-023 drop_hold SHALL equal (key_q == 0x51), registered.
REQ-024 Only one key exists per cycle, so at most one of left_pulse, right_pulse, rotate_pulse and drop_hold SHALL be high in any cycle.
REQ-025 started SHALL set on the first recognized key_q and SHALL clear only on Reset.
REQ-026 cnt SHALL never wrap: DAS and REPEAT terminal compares precede the increment.

Reset
REQ-027 Reset SHALL clear key_q, prev_q, cnt, dir, all pulses, drop_hold and started, and SHALL set rep_state to IDLE.
REQ-028 Reset asserted mid-hold SHALL abort any pending repeat; a key still held after Reset deasserts counts as a new press, since prev_q is 0x00.
REQ-029 Reset SHALL take priority over all keycode activity in the same cycle.

Verification
REQ-030 Tap 0x50 for 1 cycle, then 0x00 -> exactly one left_pulse, rep_state returns to IDLE, started=1.
REQ-031 Hold 0x4F for 20 cycles (defaults) -> right_pulse at hold cycles 1, 10, 13, 16, 19 (relative to the first sample, plus 1 cycle of latency), with no others.
REQ-032 Hold 0x50 for 5 cycles, then switch directly to 0x4F -> right_pulse the cycle after the switch, rep_state=DAS, cnt=1; no further left_pulse.
REQ-033 Hold 0x52 for 30 cycles -> exactly one rotate_pulse; rep_state remains IDLE.
REQ-034 Hold 0x51 -> drop_hold high from the second cycle through one cycle after release; no pulses.
REQ-035 Hold 0x50 and assert Reset for 2 cycles at hold cycle 12 -> all outputs 0 during Reset, started=0, then a fresh left_pulse with the DAS count restarting.
